// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
//   Writer side of the instruction memory. It fills the memory from a byte
//   stream before the CPU is released. The stream starts with a 2-byte
//   little-endian word count N, followed by 4*N bytes. Each group of four
//   bytes is assembled little-endian into one 32-bit word. The words are
//   written to consecutive byte addresses starting at BASE_ADDR.
//   While a load is pending, in progress or has failed, o_cpu_hold keeps the
//   CPU in reset.
//
// Ports
//   clk           clock; every state change happens on the rising edge
//   rst           asynchronous, active-high reset
//   i_start       pulse that arms a new load (honoured in IDLE/DONE/ERR)
//   i_in_data     stream byte
//   i_in_valid    i_in_data is valid
//   o_in_ready    loader accepts a byte this cycle (depends on state only)
//   o_wr_en       memory write strobe, one cycle per word
//   o_wr_addr     byte address of the word being written
//   o_wr_data     assembled instruction word (qualify with o_wr_en)
//   o_words_done  words written in the current load
//   o_done        load finished successfully (level)
//   o_error       word count was zero or above MAX_WORDS (level)
//   o_cpu_hold    1 = keep the CPU in reset
// -----------------------------------------------------------------------------
module instr_loader #(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           MAX_WORDS  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [7:0]            i_in_data,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic [15:0]           o_words_done,
  output logic                  o_done,
  output logic                  o_error,
  output logic                  o_cpu_hold
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t                r_state;
  logic [15:0]           r_len;
  logic [23:0]           r_shift;      // first three bytes of the current word
  logic [1:0]            r_k;          // byte index within the current word
  logic                  r_in_ready;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [15:0]           r_words_done;
  logic                  r_done;
  logic                  r_error;
  logic                  r_cpu_hold;

  logic                  w_accept;
  logic [15:0]           w_len;
  logic                  w_len_bad;
  logic [15:0]           w_next_count;
  logic [ADDR_WIDTH-1:0] w_word_addr;

  assign w_accept     = i_in_valid && r_in_ready;
  assign w_len        = {i_in_data, r_len[7:0]};
  assign w_len_bad    = (w_len == 16'd0) || (32'(w_len) > MAX_WORDS);
  assign w_next_count = r_words_done + 16'd1;
  // The address wraps naturally modulo 2**ADDR_WIDTH through truncation.
  assign w_word_addr  = BASE_ADDR + ADDR_WIDTH'({r_words_done, 2'b00});

  // in_ready is registered alongside every state change, so it always
  // reflects the state. It is 1 exactly in LEN_LO, LEN_HI and DATA.
  // NOTE: the reset branch is asynchronous (in the sensitivity list), and all
  // state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_shift      <= '0;
      r_k          <= '0;
      r_in_ready   <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_words_done <= '0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_cpu_hold   <= 1'b1;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (i_start) begin
            r_state      <= S_LEN_LO;
            r_in_ready   <= 1'b1;
            r_words_done <= '0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_cpu_hold   <= 1'b1;
          end
        end
        S_LEN_LO: begin
          if (w_accept) begin
            r_len[7:0] <= i_in_data;
            r_state    <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (w_accept) begin
            r_len <= w_len;
            if (w_len_bad) begin
              r_state    <= S_ERR;
              r_in_ready <= 1'b0;
              r_error    <= 1'b1;
              r_cpu_hold <= 1'b1;
            end else begin
              r_state <= S_DATA;
              r_k     <= '0;
            end
          end
        end
        S_DATA: begin
          if (w_accept) begin
            if (r_k == 2'd3) begin
              // Fourth byte goes straight into the word; the strobe follows next cycle.
              r_state    <= S_WRITE;
              r_in_ready <= 1'b0;
              r_wr_en    <= 1'b1;
              r_wr_addr  <= w_word_addr;
              r_wr_data  <= DATA_WIDTH'({i_in_data, r_shift});
            end else begin
              // Shift right so byte 0 ends up in the least significant lane.
              r_shift <= {i_in_data, r_shift[23:8]};
              r_k     <= r_k + 2'd1;
            end
          end
        end
        S_WRITE: begin
          r_words_done <= w_next_count;
          if (w_next_count == r_len) begin
            r_state    <= S_DONE;
            r_done     <= 1'b1;
            r_cpu_hold <= 1'b0;
          end else begin
            r_state    <= S_DATA;
            r_in_ready <= 1'b1;
            r_k        <= '0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready   = r_in_ready;
  assign o_wr_en      = r_wr_en;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_words_done = r_words_done;
  assign o_done       = r_done;
  assign o_error      = r_error;
  assign o_cpu_hold   = r_cpu_hold;

endmodule

// File: tb/tb_instr_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_loader
//   Directed and randomized bench for instr_loader. The reference model is the
//   list of words handed to each load. The expected memory writes are
//   BASE + 4*i paired with word i. These are compared against every strobe the
//   monitor captures. A second instance with MAX_WORDS=4 shares the inputs and
//   is used for the count-limit boundary.
// -----------------------------------------------------------------------------
module tb_instr_loader;

  localparam logic [15:0] BASE = 16'h0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready, wr_en, done, error, cpu_hold;
  logic [15:0] wr_addr, words_done;
  logic [31:0] wr_data;
  logic        s_in_ready, s_wr_en, s_done, s_error, s_cpu_hold;
  logic [15:0] s_wr_addr, s_words_done;
  logic [31:0] s_wr_data;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    logic        rdy;
  } wr_t;
  wr_t wq[$];

  instr_loader #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_in_data(in_data),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .o_wr_en(wr_en),
    .o_wr_addr(wr_addr), .o_wr_data(wr_data), .o_words_done(words_done),
    .o_done(done), .o_error(error), .o_cpu_hold(cpu_hold)
  );

  instr_loader #(.BASE_ADDR(BASE), .MAX_WORDS(4)) dut_s (
    .clk(clk), .rst(rst), .i_start(start), .i_in_data(in_data),
    .i_in_valid(in_valid), .o_in_ready(s_in_ready), .o_wr_en(s_wr_en),
    .o_wr_addr(s_wr_addr), .o_wr_data(s_wr_data), .o_words_done(s_words_done),
    .o_done(s_done), .o_error(s_error), .o_cpu_hold(s_cpu_hold)
  );

  always #5 clk = ~clk;

  // Capture every write strobe of the main instance, mid-cycle.
  always @(negedge clk) begin
    if (wr_en === 1'b1) wq.push_back('{wr_addr, wr_data, in_ready});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"},   in_ready,   1'b0);
    check({tag, "_wr_en"},      wr_en,      1'b0);
    check({tag, "_wr_addr"},    wr_addr,    16'h0);
    check({tag, "_wr_data"},    wr_data,    32'h0);
    check({tag, "_words_done"}, words_done, 16'h0);
    check({tag, "_done"},       done,       1'b0);
    check({tag, "_error"},      error,      1'b0);
    check({tag, "_cpu_hold"},   cpu_hold,   1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Start pulse spanning one rising edge. At the next mid-cycle the loader
  // must be armed, with done/error cleared and the CPU held.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("armed_in_ready",   in_ready,   1'b1);
    check("armed_cpu_hold",   cpu_hold,   1'b1);
    check("armed_done",       done,       1'b0);
    check("armed_error",      error,      1'b0);
    check("armed_words_done", words_done, 16'h0);
  endtask

  // Offer one byte, optionally after random idle cycles that may carry stray
  // start pulses. Returns at the mid-cycle after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit noise);
    int n;
    if (gaps) begin
      int g;
      g = $urandom_range(0, 3);
      repeat (g) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        start    = noise && ($urandom_range(0, 2) == 0);
        @(negedge clk);
      end
    end
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_len(input logic [15:0] len, input bit gaps, input bit noise);
    send_byte(len[7:0], gaps, noise);
    send_byte(len[15:8], gaps, noise);
  endtask

  // Full load of the given words, then compare every strobe with the model.
  task automatic run_load(input logic [31:0] words[$], input bit gaps, input bit noise);
    int          len;
    int          base;
    int          n;
    logic [31:0] w;
    len  = words.size();
    base = wq.size();
    send_len(16'(len), gaps, noise);
    for (int i = 0; i < len; i++) begin
      w = words[i];
      for (int k = 0; k < 4; k++) begin
        send_byte(w[8*k +: 8], gaps, noise);
      end
      // The fourth byte was taken at the last edge, so the strobe is up now.
      check("strobe_latency", wr_en,    1'b1);
      check("strobe_ready",   in_ready, 1'b0);
      check("strobe_addr",    wr_addr,  16'(BASE + 4 * i));
      check("strobe_data",    wr_data,  w);
    end
    n = 0;
    while (done !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("load_done",       done,       1'b1);
    check("load_cpu_hold",   cpu_hold,   1'b0);
    check("load_error",      error,      1'b0);
    check("load_words_done", words_done, 16'(len));
    check("load_strobes",    wq.size() - base, len);
    for (int i = 0; i < len && base + i < wq.size(); i++) begin
      check("mem_addr", wq[base + i].addr, 16'(BASE + 4 * i));
      check("mem_data", wq[base + i].data, words[i]);
      check("mem_rdy",  wq[base + i].rdy,  1'b0);
    end
  endtask

  initial begin
    logic [31:0] wl[$];
    int          base;
    int          len;

    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_reset("rst");
    rst = 1'b0;
    @(negedge clk);
    check_reset("idle");

    // Single word.
    pulse_start();
    wl = {32'h00A00513};
    run_load(wl, 1'b0, 1'b0);

    // Three words, sequential addresses.
    pulse_start();
    wl = {32'h11223344, 32'h55667788, 32'h99AABBCC};
    run_load(wl, 1'b0, 1'b0);

    // Zero length is rejected without any write.
    pulse_start();
    base = wq.size();
    send_len(16'h0000, 1'b0, 1'b0);
    check("len0_error",    error,     1'b1);
    check("len0_cpu_hold", cpu_hold,  1'b1);
    check("len0_in_ready", in_ready,  1'b0);
    check("len0_done",     done,      1'b0);
    check("len0_strobes",  wq.size(), base);

    // One above MAX_WORDS on the default instance.
    pulse_start();
    send_len(16'd1025, 1'b0, 1'b0);
    check("len1025_error", error, 1'b1);

    // len=5 exceeds the small instance's limit but not the main one's.
    pulse_start();
    send_len(16'd5, 1'b0, 1'b0);
    check("small_len5_error",    s_error,    1'b1);
    check("small_len5_cpu_hold", s_cpu_hold, 1'b1);
    check("main_len5_error",     error,      1'b0);
    check("main_len5_in_ready",  in_ready,   1'b1);
    do_reset();
    check_reset("after_len5");

    // Randomized loads with input gaps and ignored start pulses. The first
    // run uses len=4, which the small instance must accept exactly.
    for (int r = 0; r < 6; r++) begin
      len = (r == 0) ? 4 : int'($urandom_range(1, 6));
      wl  = {};
      for (int i = 0; i < len; i++) wl.push_back($urandom);
      pulse_start();
      run_load(wl, 1'b1, 1'b1);
      if (r == 0) begin
        check("small_len4_done",  s_done,       1'b1);
        check("small_len4_count", s_words_done, 16'd4);
        check("small_len4_error", s_error,      1'b0);
      end
    end

    // Reset after two data bytes of the first word discards the partial word.
    pulse_start();
    base = wq.size();
    send_len(16'd2, 1'b0, 1'b0);
    send_byte(8'hDE, 1'b0, 1'b0);
    send_byte(8'hAD, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check_reset("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("post_reset");
    check("mid_reset_strobes", wq.size(), base);
    pulse_start();
    wl = {32'hCAFEF00D, 32'h0BADBEEF};
    run_load(wl, 1'b1, 1'b0);

    // Reload from DONE lands at BASE again.
    pulse_start();
    wl = {32'h12345678};
    run_load(wl, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
